// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry, pixel types and the RGB332 -> RGB888 expansion.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_W   = 200;
  localparam int FB_H   = 200;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 1;
  localparam logic [15:0] NULL_ADDR = 16'hFFFF;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Beam attributes that travel alongside the framebuffer read.
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic active;
    logic in_win;
  } beam_t;

  localparam beam_t BEAM_IDLE = '{h_sync: 1'b1, v_sync: 1'b1, active: 1'b0, in_win: 1'b0};

  // Bit replication maps 0 to 0x00 and full scale to 0xFF on every channel.
  function automatic rgb888_t rgb332_to_rgb888(input rgb332_t c);
    rgb888_t o;
    o.r = {c.r, c.r, c.r[2:1]};
    o.g = {c.g, c.g, c.g[2:1]};
    o.b = {4{c.b}};
    return o;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for the VGA pixel clock: H/V position, active-low syncs, active-video flag
// and a one-cycle frame-start pulse when the counters wrap to (0,0).
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       h_sync_o,
  output logic       v_sync_o,
  output logic       active_o,
  output logic       frame_start_o
);

  localparam logic [9:0] H_LAST       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       frame_start_q, frame_start_d;

  // NOTE: every next-state signal gets a default first, so no path through the
  // block leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    h_d           = h_q + 10'd1;
    v_d           = v_q;
    frame_start_d = 1'b0;
    if (h_q == H_LAST) begin
      h_d           = '0;
      v_d           = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      frame_start_d = (v_q == V_LAST);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge
  // values no matter how the statements are ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign h_sync_o      = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
  assign v_sync_o      = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
  assign active_o      = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: column-major read addressing, sync/blank delay matched to the RAM latency,
// RGB332 expansion to the DAC pins. Define VGA_SCALE2X_EN to show each fb pixel as a 2x2 block.
module vga_fb_scanout #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int FB_W     = vga_pkg::FB_W,
  parameter int FB_H     = vga_pkg::FB_H,
  parameter int ADDR_W   = vga_pkg::ADDR_W,
  parameter int RD_LAT   = vga_pkg::RD_LAT,
  parameter logic [ADDR_W-1:0] NULL_ADDR = ADDR_W'(vga_pkg::NULL_ADDR)
) (
  input  logic              clk_vga,
  input  logic              reset,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [31:0]       fb_rdata,
  output logic              h_sync,
  output logic              v_sync,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic [9:0]        column,
  output logic [9:0]        row,
  output logic              visible,
  output logic              frame_start
);

  import vga_pkg::*;

`ifdef VGA_SCALE2X_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif

  localparam logic [9:0]        WIN_W    = 10'(FB_W << SCALE_SH);
  localparam logic [9:0]        WIN_H    = 10'(FB_H << SCALE_SH);
  localparam logic [9:0]        H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(FB_H);

  logic [9:0] h_cnt, v_cnt;
  logic       tg_h_sync, tg_v_sync, tg_active;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk_vga),
    .rst_n         (reset),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .h_sync_o      (tg_h_sync),
    .v_sync_o      (tg_v_sync),
    .active_o      (tg_active),
    .frame_start_o (frame_start)
  );

  logic              in_win;
  logic              col_step;
  logic [9:0]        fb_row;
  logic [ADDR_W-1:0] col_off_q, col_off_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;

  assign in_win = (h_cnt < WIN_W) && (v_cnt < WIN_H);

  // col_off_q always equals fb_x * FB_H for the current h_cnt; it advances once
  // per framebuffer column and stops at the window edge so it never overflows.
`ifdef VGA_SCALE2X_EN
  assign col_step = (h_cnt < WIN_W) && h_cnt[0];
  assign fb_row   = {1'b0, v_cnt[9:1]};
`else
  assign col_step = (h_cnt < WIN_W);
  assign fb_row   = v_cnt;
`endif

  always_comb begin
    col_off_d = col_off_q;
    if (h_cnt == H_LAST) begin
      col_off_d = '0;
    end else if (col_step) begin
      col_off_d = col_off_q + COL_STEP;
    end
    fb_addr_d = in_win ? (col_off_q + ADDR_W'(fb_row)) : NULL_ADDR;
  end

  beam_t   beam_d;
  beam_t   beam_q [RD_LAT+1];
  beam_t   pin_beam;
  beam_t   pin_q;
  rgb888_t rgb_d, rgb_q;

  assign beam_d   = '{h_sync: tg_h_sync, v_sync: tg_v_sync, active: tg_active, in_win: in_win};
  assign pin_beam = beam_q[RD_LAT];
  assign rgb_d    = (pin_beam.active && pin_beam.in_win)
                  ? rgb332_to_rgb888(rgb332_t'(fb_rdata[7:0])) : '0;

  always_ff @(posedge clk_vga or negedge reset) begin
    if (!reset) begin
      col_off_q <= '0;
      fb_addr_q <= NULL_ADDR;
      // NOTE: the delay line is only RD_LAT+1 entries deep and must come out of
      // reset inactive, so it is reset like ordinary flops rather than left as RAM.
      for (int i = 0; i <= RD_LAT; i++) begin
        beam_q[i] <= BEAM_IDLE;
      end
      pin_q <= BEAM_IDLE;
      rgb_q <= '0;
    end else begin
      col_off_q <= col_off_d;
      fb_addr_q <= fb_addr_d;
      beam_q[0] <= beam_d;
      for (int i = 1; i <= RD_LAT; i++) begin
        beam_q[i] <= beam_q[i-1];
      end
      pin_q <= pin_beam;
      rgb_q <= rgb_d;
    end
  end

  // Only the RGB332 byte of the framebuffer word is displayed.
  logic rdata_unused;
  assign rdata_unused = ^fb_rdata[31:8];

  assign fb_addr     = fb_addr_q;
  assign h_sync      = pin_q.h_sync;
  assign v_sync      = pin_q.v_sync;
  assign vga_blank_n = pin_q.active;
  assign visible     = pin_q.in_win;
  assign vga_sync_n  = 1'b0;
  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;
  assign column      = h_cnt;
  assign row         = v_cnt;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: a full-size instance (RD_LAT=1, mem[a]=a[7:0]) and a shrunken-timing
// instance (RD_LAT=2, random framebuffer) are both compared every cycle against a raster model.
module tb_vga_fb_scanout;

  localparam int S_HA = 32, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VA = 24, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int FRAME_S = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cur = 0;

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [7:0] d);
    int r3, g3, b2;
    r3 = int'(d) / 32;
    g3 = (int'(d) / 4) % 8;
    b2 = int'(d) % 4;
    return {8'(r3 * 32 + r3 * 4 + r3 / 2), 8'(g3 * 32 + g3 * 4 + g3 / 2), 8'(b2 * 85)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int HA  = (g == 0) ? 640 : S_HA;
    localparam int HF  = (g == 0) ? 16  : S_HF;
    localparam int HS  = (g == 0) ? 96  : S_HS;
    localparam int HB  = (g == 0) ? 48  : S_HB;
    localparam int VA  = (g == 0) ? 480 : S_VA;
    localparam int VF  = (g == 0) ? 10  : S_VF;
    localparam int VS  = (g == 0) ? 2   : S_VS;
    localparam int VB  = (g == 0) ? 33  : S_VB;
    localparam int FW  = (g == 0) ? 200 : 12;
    localparam int FH  = (g == 0) ? 200 : 10;
    localparam int LAT = (g == 0) ? 1   : 2;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;

    logic [15:0] fb_addr;
    logic [31:0] fb_rdata;
    logic        h_sync, v_sync, blank_n, sync_n, visible, frame_start;
    logic [7:0]  red, green, blue;
    logic [9:0]  column, row;
    logic [28:0] pins;
    logic [7:0]  mem [65536];
    logic [31:0] rd_pipe [LAT];
    int          n = 0;

    vga_fb_scanout #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .FB_W (FW), .FB_H (FH), .ADDR_W (16), .RD_LAT (LAT), .NULL_ADDR (16'hFFFF)
    ) dut (
      .clk_vga     (clk),
      .reset       (rst_n),
      .fb_addr     (fb_addr),
      .fb_rdata    (fb_rdata),
      .h_sync      (h_sync),
      .v_sync      (v_sync),
      .vga_blank_n (blank_n),
      .vga_sync_n  (sync_n),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .column      (column),
      .row         (row),
      .visible     (visible),
      .frame_start (frame_start)
    );

    assign pins = {sync_n, h_sync, v_sync, blank_n, visible, red, green, blue};

    initial begin
      for (int a = 0; a < 65536; a++) begin
        mem[a] = (g == 0) ? 8'(a) : 8'($urandom);
      end
    end

    // Synchronous RAM of depth LAT; upper data bits are noise the DUT must ignore.
    always @(posedge clk) begin
      rd_pipe[0] <= {24'($urandom), mem[fb_addr]};
      for (int i = 1; i < LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
    assign fb_rdata = rd_pipe[LAT-1];

    function automatic bit in_window(input int h, input int v);
`ifdef VGA_SCALE2X_EN
      return (h < 2 * FW) && (v < 2 * FH);
`else
      return (h < FW) && (v < FH);
`endif
    endfunction

    function automatic logic [15:0] exp_addr(input int h, input int v);
      int fx, fy;
`ifdef VGA_SCALE2X_EN
      fx = h / 2;
      fy = v / 2;
`else
      fx = h;
      fy = v;
`endif
      if (!in_window(h, v)) return 16'hFFFF;
      return 16'(fy + fx * FH);
    endfunction

    // Pin values for the pixel the counters showed in cycle c (c < 0: before the first pixel).
    function automatic logic [28:0] exp_pins(input int c);
      int h, v;
      logic hs, vs, act, win;
      logic [23:0] rgb;
      if (c < 0) return {1'b0, 4'b1100, 24'h0};
      h   = c % HT;
      v   = (c / HT) % VT;
      hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      act = (h < HA) && (v < VA);
      win = in_window(h, v);
      rgb = (act && win) ? exp_rgb(mem[exp_addr(h, v)]) : 24'h0;
      return {1'b0, hs, vs, act, win, rgb};
    endfunction

    always @(negedge clk) begin
      if (!rst_n) begin
        check($sformatf("cfg%0d reset pins", g), 64'(pins), 64'(exp_pins(-1)));
        check($sformatf("cfg%0d reset addr", g), 64'(fb_addr), 64'hFFFF);
        check($sformatf("cfg%0d reset ctr", g), 64'({frame_start, column, row}), 64'd0);
        n = 0;
      end else begin
        check($sformatf("cfg%0d addr @%0d", g, n), 64'(fb_addr),
              64'((n == 0) ? 16'hFFFF : exp_addr((n - 1) % HT, ((n - 1) / HT) % VT)));
        check($sformatf("cfg%0d pins @%0d", g, n), 64'(pins), 64'(exp_pins(n - LAT - 2)));
        check($sformatf("cfg%0d ctr @%0d", g, n), 64'({frame_start, column, row}),
              64'({(n > 0) && (n % (HT * VT) == 0), 10'(n % HT), 10'((n / HT) % VT)}));
        n++;
      end
    end
  end

  task automatic to_cycle(input int k);
    repeat (k - cur) @(negedge clk);
    cur = k;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cur = 0;

    // Fixed landmarks of the full-size raster with mem[a] = a[7:0].
`ifdef VGA_SCALE2X_EN
    to_cycle(1);    check("x2 addr (0,0)", 64'(cfg[0].fb_addr), 64'd0);
    to_cycle(2);    check("x2 addr (1,0)", 64'(cfg[0].fb_addr), 64'd0);
    to_cycle(3);    check("x2 pins (0,0)", 64'(cfg[0].pins), 64'h0F000000);
    to_cycle(4);    check("x2 addr (3,0)", 64'(cfg[0].fb_addr), 64'd200);
    to_cycle(6);    check("x2 pins (3,0)", 64'(cfg[0].pins), 64'h0FDB4900);
    to_cycle(401);  check("x2 addr (399,0)", 64'(cfg[0].fb_addr), 64'd39800);
    to_cycle(402);  check("x2 addr (400,0)", 64'(cfg[0].fb_addr), 64'hFFFF);
                    check("x2 vis (399,0)", 64'(cfg[0].visible), 64'd1);
    to_cycle(403);  check("x2 vis (400,0)", 64'(cfg[0].visible), 64'd0);
    to_cycle(658);  check("x2 hsync 655", 64'(cfg[0].h_sync), 64'd1);
    to_cycle(659);  check("x2 hsync 656", 64'(cfg[0].h_sync), 64'd0);
    to_cycle(4004); check("x2 addr (3,5)", 64'(cfg[0].fb_addr), 64'd202);
`else
    to_cycle(1);    check("addr (0,0)", 64'(cfg[0].fb_addr), 64'd0);
    to_cycle(2);    check("addr (1,0)", 64'(cfg[0].fb_addr), 64'd200);
    to_cycle(3);    check("pins (0,0)", 64'(cfg[0].pins), 64'h0F000000);
    to_cycle(4);    check("pins (1,0)", 64'(cfg[0].pins), 64'h0FDB4900);
    to_cycle(200);  check("addr (199,0)", 64'(cfg[0].fb_addr), 64'd39800);
    to_cycle(201);  check("addr (200,0)", 64'(cfg[0].fb_addr), 64'hFFFF);
    to_cycle(203);  check("pins (200,0)", 64'(cfg[0].pins), 64'h0E000000);
    to_cycle(658);  check("hsync 655", 64'(cfg[0].h_sync), 64'd1);
    to_cycle(659);  check("hsync 656", 64'(cfg[0].h_sync), 64'd0);
    to_cycle(754);  check("hsync 751", 64'(cfg[0].h_sync), 64'd0);
    to_cycle(755);  check("hsync 752", 64'(cfg[0].h_sync), 64'd1);
`endif

    // Three small frames, then a reset dropped at a random point mid-frame.
    to_cycle(3 * FRAME_S + int'($urandom_range(40, FRAME_S - 40)));
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (int'($urandom_range(1, 4))) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cur = 0;
    to_cycle(2 * FRAME_S + 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
